// File: rtl/ir_key_ctrl_pkg.sv
// Shared definitions for the IR key controller: event codes, FSM states,
// event word layout and a helper that packs a key into an event word.
package ir_key_ctrl_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_REPEAT  = 2'd1;
    localparam logic [1:0] EVT_RELEASE = 2'd2;

    // Event word is {type[1:0], addr[15:0], cmd[7:0]}
    localparam int unsigned EVT_W = 26;
    // Key is {addr[15:0], cmd[7:0]}
    localparam int unsigned KEY_W = 24;
    // Millisecond timer width
    localparam int unsigned TMR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_SWAP = 2'd2
    } key_state_e;

    typedef struct packed {
        logic [1:0]  typ;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } key_evt_t;

    function automatic key_evt_t make_evt(input logic [1:0] typ, input logic [KEY_W-1:0] key);
        key_evt_t e;
        e.typ  = typ;
        e.addr = key[23:8];
        e.cmd  = key[7:0];
        return e;
    endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Small synchronous event FIFO. Head word is presented combinationally from
// the storage array; a push on a full FIFO is accepted only when a pop frees
// a slot in the same cycle. DEPTH must be a power of two so pointers wrap.
module ir_evt_fifo
    import ir_key_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = EVT_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    // Storage; cleared on reset so the head reads as zero after a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ir_key_ctrl.sv
// NEC frame to key-event sequencer. Checks frame inversion bytes, filters by
// address, tracks the held key with a millisecond hold timer and generates
// PRESS / REPEAT / RELEASE events into an event FIFO.
//
// Event handshake: evt_valid is high while the FIFO holds an event; the head
// event on evt_type/evt_addr/evt_cmd is consumed on a cycle where both
// evt_valid and evt_ready are high, and stays stable otherwise.
module ir_key_ctrl
    import ir_key_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 100_000,
    parameter int unsigned HOLD_TIMEOUT_MS = 120,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 200,
    parameter int unsigned EXT_ADDR        = 0,
    parameter int unsigned ADDR_FILTER     = 0,
    parameter logic [15:0] ADDR_MATCH      = 16'h00FF,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] frame,
    input  logic        frame_valid,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_type,
    output logic [15:0] evt_addr,
    output logic [7:0]  evt_cmd,
    output logic        held,
    output logic [7:0]  err_cnt,
    output logic [7:0]  ovf_cnt,
    output key_state_e  dbg_state_o
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    key_state_e         state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [KEY_W-1:0]   pend_q, pend_d;
    logic [TMR_W-1:0]   hold_tmr_q, hold_tmr_d;
    logic [TMR_W-1:0]   rpt_tmr_q, rpt_tmr_d;
    logic               rpt_first_q, rpt_first_d;
    logic [PRESC_W-1:0] presc_q;
    logic [7:0]         err_cnt_q;
    logic [7:0]         ovf_cnt_q;

    logic               ms_tick;
    logic               chk_ok;
    logic [15:0]        f_addr;
    logic [15:0]        match_addr;
    logic               addr_pass;
    logic               frame_bad;
    logic               frame_good;
    logic [KEY_W-1:0]   f_key;
    logic               new_key;
    logic               hold_due;
    logic               rpt_due;
    logic [TMR_W:0]     rpt_target;

    logic               push;
    key_evt_t           push_evt;
    logic [EVT_W-1:0]   head_word;
    key_evt_t           head_evt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               evt_pop;
    logic               drop;

    // ---------------- frame checker ----------------
    assign chk_ok     = ((frame[15:8] ^ frame[7:0]) == 8'hFF) &&
                        ((EXT_ADDR != 0) || ((frame[31:24] ^ frame[23:16]) == 8'hFF));
    assign f_addr     = (EXT_ADDR != 0) ? frame[31:16] : {8'h00, frame[31:24]};
    assign match_addr = (EXT_ADDR != 0) ? ADDR_MATCH : {8'h00, ADDR_MATCH[7:0]};
    assign addr_pass  = (ADDR_FILTER == 0) || (f_addr == match_addr);
    assign frame_bad  = frame_valid && !chk_ok;
    assign frame_good = frame_valid && chk_ok && addr_pass;
    assign f_key      = {f_addr, frame[15:8]};
    assign new_key    = (f_key != key_q);

    // ---------------- timers ----------------
    // Timeouts fire on the ms tick that brings a timer to its limit; using >=
    // lets a repeat that lost its tick to a higher-priority action fire on
    // the following tick.
    assign ms_tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign rpt_target = rpt_first_q ? (TMR_W+1)'(REPEAT_DELAY_MS) : (TMR_W+1)'(REPEAT_RATE_MS);
    assign hold_due   = ms_tick && (({1'b0, hold_tmr_q} + (TMR_W+1)'(1)) >= (TMR_W+1)'(HOLD_TIMEOUT_MS));
    assign rpt_due    = ms_tick && (({1'b0, rpt_tmr_q} + (TMR_W+1)'(1)) >= rpt_target);

    // Millisecond prescaler, free running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (ms_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // ---------------- key FSM ----------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: frame beats hold timeout; SWAP always lasts one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (frame_good) state_d = ST_HELD;
            ST_HELD: begin
                if (frame_good) begin
                    if (new_key) state_d = ST_SWAP;
                end else if (hold_due) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWAP: state_d = ST_HELD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: event push and key/timer updates; priority frame > timeout > repeat
    always_comb begin
        push        = 1'b0;
        push_evt    = '0;
        key_d       = key_q;
        pend_d      = pend_q;
        hold_tmr_d  = hold_tmr_q;
        rpt_tmr_d   = rpt_tmr_q;
        rpt_first_d = rpt_first_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_good) begin
                    push        = 1'b1;
                    push_evt    = make_evt(EVT_PRESS, f_key);
                    key_d       = f_key;
                    hold_tmr_d  = '0;
                    rpt_tmr_d   = '0;
                    rpt_first_d = 1'b1;
                end
            end
            ST_HELD: begin
                if (frame_good && new_key) begin
                    push     = 1'b1;
                    push_evt = make_evt(EVT_RELEASE, key_q);
                    pend_d   = f_key;
                end else if (frame_good) begin
                    // Same key refreshes the hold; a due repeat slips a tick
                    hold_tmr_d = '0;
                    if (ms_tick) rpt_tmr_d = rpt_tmr_q + TMR_W'(1);
                end else if (hold_due) begin
                    push     = 1'b1;
                    push_evt = make_evt(EVT_RELEASE, key_q);
                end else if (rpt_due) begin
                    push        = 1'b1;
                    push_evt    = make_evt(EVT_REPEAT, key_q);
                    rpt_tmr_d   = '0;
                    rpt_first_d = 1'b0;
                    hold_tmr_d  = hold_tmr_q + TMR_W'(1);
                end else if (ms_tick) begin
                    hold_tmr_d = hold_tmr_q + TMR_W'(1);
                    rpt_tmr_d  = rpt_tmr_q + TMR_W'(1);
                end
            end
            ST_SWAP: begin
                // A frame arriving here can only match or be dropped; either
                // way the pending key already holds the right value.
                push        = 1'b1;
                push_evt    = make_evt(EVT_PRESS, pend_q);
                key_d       = pend_q;
                hold_tmr_d  = '0;
                rpt_tmr_d   = '0;
                rpt_first_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Key, pending key and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            pend_q      <= '0;
            hold_tmr_q  <= '0;
            rpt_tmr_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            key_q       <= key_d;
            pend_q      <= pend_d;
            hold_tmr_q  <= hold_tmr_d;
            rpt_tmr_q   <= rpt_tmr_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    // ---------------- event FIFO ----------------
    assign evt_pop = evt_valid && evt_ready;
    assign drop    = push && fifo_full && !evt_pop;

    ir_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_evt),
        .pop_i   (evt_pop),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_evt = head_word;

    // Saturating error and overflow counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (frame_bad && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
            if (drop && (ovf_cnt_q != 8'hFF))      ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign evt_valid   = !fifo_empty;
    assign evt_type    = fifo_empty ? 2'd0  : head_evt.typ;
    assign evt_addr    = fifo_empty ? 16'd0 : head_evt.addr;
    assign evt_cmd     = fifo_empty ? 8'd0  : head_evt.cmd;
    assign held        = (state_q != ST_IDLE);
    assign err_cnt     = err_cnt_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign dbg_state_o = state_q;

endmodule
